seq_divider: RTL and testbench

//  Sequential restoring shift-subtract divider, the inverse of the team's shift-add multiplier.

---
 rtl/div_pkg.sv | 18 +
 rtl/seq_div_ctrl.sv | 92 +++++++++
 rtl/seq_divider.sv | 126 ++++++++++++
 tb/tb_seq_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared types and defaults for the sequential restoring divider.
//   - DIV_WIDTH_D : default operand width. It matches the shift-add
//                   multiplier that sits beside the divider.
//   - div_state_t : control FSM encoding (IDLE -> RUN -> DONE -> IDLE).
// ---------------------------------------------------------------------------
package div_pkg;

   localparam int DIV_WIDTH_D = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_div_ctrl.sv
// ---------------------------------------------------------------------------
// seq_div_ctrl
//   Control FSM and iteration counter for seq_divider. The datapath registers
//   live in the parent; this block only issues strobes to it.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-high reset
//     flush      in   synchronous abort (same effect as reset, on next edge)
//     in_valid   in   operands offered
//     out_ready  in   consumer takes the result
//     skip       in   operation can go straight to DONE (zero operand bypass)
//     in_ready   out  idle, operands can be accepted
//     out_valid  out  result is presented
//     load       out  capture operands this edge
//     step       out  perform one restoring iteration this edge
// ---------------------------------------------------------------------------
module seq_div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH_D = DIV_WIDTH_D,
   parameter int WIDTH_C = $clog2(WIDTH_D)
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic in_valid,
   input  logic out_ready,
   input  logic skip,
   output logic in_ready,
   output logic out_valid,
   output logic load,
   output logic step
);

   localparam logic [WIDTH_C-1:0] LAST_ITER = WIDTH_C'(WIDTH_D - 1);

   div_state_t         state_q, state_d;
   logic [WIDTH_C-1:0] count_q, count_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               count_d = '0;
               state_d = skip ? DONE : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count_q == LAST_ITER) begin
               count_d = '0;
               state_d = DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // No accept in this cycle: IDLE is only reached on the next edge.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential restoring shift-subtract divider (unsigned). It produces one
//   quotient bit per clock, so a full divide takes WIDTH_D iterations.
//   Division by zero falls out of the restoring algorithm naturally:
//   quotient = all ones, remainder = dividend, and div_by_zero is raised.
//
//   Optional feature: define ZERO_BYPASS_EN to send zero-divisor or
//   zero-dividend operations straight from IDLE to DONE. The results are
//   the same as a full run.
//
//   Ports
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-high reset, clears all state
//     flush        in   synchronous abort, discards any operation in flight
//     in_valid     in   operands valid
//     in_ready     out  divider idle, can accept
//     dividend     in   [WIDTH_D] numerator, sampled on accept
//     divisor      in   [WIDTH_D] denominator, sampled on accept
//     out_valid    out  quotient/remainder valid
//     out_ready    in   consumer accepts result
//     quotient     out  [WIDTH_D] result quotient
//     remainder    out  [WIDTH_D] result remainder
//     div_by_zero  out  divisor was zero; qualified by out_valid
// ---------------------------------------------------------------------------
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH_D = DIV_WIDTH_D,
   parameter int WIDTH_C = $clog2(WIDTH_D)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_D-1:0] dividend,
   input  logic [WIDTH_D-1:0] divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_D-1:0] quotient,
   output logic [WIDTH_D-1:0] remainder,
   output logic               div_by_zero
);

   logic load;
   logic step;
   logic skip;

`ifdef ZERO_BYPASS_EN
   assign skip = (divisor == '0) || (dividend == '0);
`else
   assign skip = 1'b0;
`endif

   seq_div_ctrl #(
      .WIDTH_D (WIDTH_D),
      .WIDTH_C (WIDTH_C)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .skip      (skip),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .load      (load),
      .step      (step)
   );

   // q_q starts as the dividend. Each step shifts one dividend bit out of its
   // MSB into the partial remainder and shifts one quotient bit into its LSB.
   logic [WIDTH_D-1:0] q_q;
   logic [WIDTH_D-1:0] r_q;
   logic [WIDTH_D-1:0] d_q;
   logic               dbz_q;

   // The partial remainder always fits in WIDTH_D bits: it is below the
   // divisor, or for a zero divisor it holds at most WIDTH_D shifted-in bits.
   // Only the shifted value and the trial difference need the extra bit.
   logic [WIDTH_D:0] shifted;
   logic [WIDTH_D:0] trial;

   assign shifted = {r_q, q_q[WIDTH_D-1]};
   assign trial   = shifted - {1'b0, d_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q   <= '0;
         r_q   <= '0;
         d_q   <= '0;
         dbz_q <= 1'b0;
      end else if (flush) begin
         q_q   <= '0;
         r_q   <= '0;
         d_q   <= '0;
         dbz_q <= 1'b0;
      end else if (load) begin
         d_q   <= divisor;
         dbz_q <= (divisor == '0);
         if (skip) begin
            // Final values of a full run: x/0 -> (all ones, x), 0/d -> (0, 0).
            // In both cases the remainder equals the dividend.
            q_q <= (divisor == '0) ? '1 : '0;
            r_q <= dividend;
         end else begin
            q_q <= dividend;
            r_q <= '0;
         end
      end else if (step) begin
         if (!trial[WIDTH_D]) begin
            r_q <= trial[WIDTH_D-1:0];
            q_q <= {q_q[WIDTH_D-2:0], 1'b1};
         end else begin
            r_q <= shifted[WIDTH_D-1:0];
            q_q <= {q_q[WIDTH_D-2:0], 1'b0};
         end
      end
   end

   assign quotient    = q_q;
   assign remainder   = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider (16-bit). Stimulus pushes the
// hand-computed result of every accepted operation; a monitor pops and
// compares whenever a result is consumed.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_divider dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Monitor: a result is consumed at the next rising edge when both valid
   // and ready are high; sample on the falling edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: got q=%0d r=%0d dbz=%0d required no result",
                     quotient, remainder, div_by_zero);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("result %0d/%0d: q=%0d r=%0d dbz=%0d", e.a, e.b, quotient, remainder, div_by_zero);
            chk($sformatf("quot_%0d_%0d", e.a, e.b), 32'(quotient), 32'(e.q));
            chk($sformatf("rem_%0d_%0d", e.a, e.b), 32'(remainder), 32'(e.r));
            chk($sformatf("dbz_%0d_%0d", e.a, e.b), 32'(div_by_zero), 32'(e.dbz));
         end
      end
   end

   // Offer operands, wait (bounded) for in_ready, return just after the
   // accept edge. push=0 marks an operation that is expected to be discarded.
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r,
                       input logic dbz, input bit push);
      int n;
      exp_t e;
      n = 0;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(n), 32'(0));
      end else begin
         if (push) begin
            e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Edges after the accept edge until out_valid is observed.
   task automatic measure_latency(input string name, input int req);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, 32'(n), 32'(req));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'(0));
   endtask

   int lat_zero;

   initial begin
`ifdef ZERO_BYPASS_EN
      lat_zero = 0;
`else
      lat_zero = 16;
`endif
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_quotient", 32'(quotient), 32'd0);
      chk("reset_remainder", 32'(remainder), 32'd0);
      chk("reset_dbz", 32'(div_by_zero), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic divide with full-run latency.
      send(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
      measure_latency("latency_100_7", 16);
      drain();

      // Boundary operands, back to back.
      send(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 1'b1);
      send(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 1'b1);
      drain();

      // Zero divisor and zero dividend.
      send(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b1);
      measure_latency("latency_5_0", lat_zero);
      drain();
      send(16'd0, 16'd9, 16'd0, 16'd0, 1'b0, 1'b1);
      measure_latency("latency_0_9", lat_zero);
      drain();

      // Consumer stall: the result must hold and a held in_valid is ignored.
      out_ready = 1'b0;
      send(16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0, 1'b1);
      measure_latency("latency_ffff_ffff", 16);
      in_valid = 1'b1;
      dividend = 16'd1000;
      divisor  = 16'd10;
      begin
         exp_t e;
         e.a = 16'd1000; e.b = 16'd10; e.q = 16'd100; e.r = 16'd0; e.dbz = 1'b0;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_quotient", 32'(quotient), 32'd1);
         chk("stall_remainder", 32'(remainder), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("consume_no_accept", 32'(in_ready), 32'd1);
      chk("consume_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Asynchronous reset in the middle of RUN discards the operation.
      send(16'd100, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (8) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      chk("midrun_reset_in_ready", 32'(in_ready), 32'd1);
      chk("midrun_reset_out_valid", 32'(out_valid), 32'd0);
      chk("midrun_reset_quotient", 32'(quotient), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      send(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 1'b1);
      drain();

      // Synchronous flush mid-RUN, then back-to-back operations.
      send(16'd1234, 16'd5, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      repeat (20) begin
         @(posedge clk); #1;
      end
      send(16'd200, 16'd3, 16'd66, 16'd2, 1'b0, 1'b1);
      send(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
      drain();

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
